multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle successor to the single-cycle MIPS opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives per-state datapath controls.
- Handshakes with a variable-latency memory through a ready input, with a bounded-wait watchdog.
- Sits between the instruction register opcode field and the multi-cycle datapath (PC, IR, register file, ALU, data memory).

Parameters:
- OP_W, 6, opcode width.
- ALU_OP_W, 3, width of alu_op_o (bits above 3 are zero-extended).
- MAX_WAIT, 15, memory-wait cycles allowed before mem_timeout_o fires; must be 1..255.
- CNT_W, 32, performance counter width (used only with the optional feature).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- instr_op_i  in  OP_W  opcode from the IR; sampled in DECODE, held stable by the datapath until the next FETCH.
- mem_ready_i  in  1  memory completes the current read or write this cycle.
- pc_write_o  out  1  PC load (fetch increment or jump).
- ir_write_o  out  1  IR load.
- reg_write_o  out  1  register file write enable.
- reg_dst_o  out  1  1 = rd, 0 = rt.
- alu_src_o  out  1  1 = immediate operand.
- alu_op_o  out  ALU_OP_W  ALU operation code.
- branch_o  out  1  conditional branch evaluate.
- branch_ne_o  out  1  branch sense: 1 = bne, 0 = beq.
- jump_o  out  1  jump target select.
- mem_read_o  out  1  memory read request.
- mem_write_o  out  1  memory write request.
- mem_to_reg_o  out  1  writeback selects memory data.
- iord_o  out  1  memory address select: 0 = PC, 1 = ALU result.
- illegal_o  out  1  one-cycle pulse on an unknown opcode.
- mem_timeout_o  out  1  sticky until reset; memory wait exceeded MAX_WAIT.
- state_o  out  3  current state code, for debug.

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5..7 are unreachable and recover to FETCH.
- Reset: state=FETCH, wait counter=0, mem_timeout_o=0. All other outputs are combinational from state plus the registered opcode and read 0 during the reset cycle.
- Opcode is registered in DECODE.
- Opcode set and decoded ALU op:
  - R-type, op 0: ALU op 000.
  - beq, op 4: ALU op 110.
  - bne, op 5: ALU op 011.
  - addi, op 8: ALU op 010.
  - sltiu, op 9: ALU op 111.
  - ori, op 13: ALU op 001.
  - lui, op 15: ALU op 100.
  - j, op 2: ALU op is don't care; drive 000.
  - lw, op 35: ALU op 010.
  - sw, op 43: ALU op 010.
- FETCH:
  - mem_read_o=1, iord_o=0.
  - While mem_ready_i=0: stay and increment the wait counter.
  - When mem_ready_i=1: ir_write_o=1 and pc_write_o=1 for that single cycle, counter cleared, go to DECODE.
- DECODE:
  - One cycle; no outputs asserted.
  - Illegal opcode: illegal_o pulses, go to FETCH.
  - Otherwise go to EXEC.
- EXEC (one cycle; alu_op_o valid):
  - alu_src_o=1 for addi/sltiu/ori/lui/lw/sw.
  - R-type/addi/sltiu/ori/lui: go to WB.
  - beq/bne: branch_o=1, branch_ne_o=(op==5), go to FETCH.
  - j: jump_o=1, pc_write_o=1, go to FETCH.
  - lw/sw: go to MEM.
- MEM:
  - iord_o=1; mem_read_o=1 for lw, mem_write_o=1 for sw.
  - Stay until mem_ready_i=1, counting as in FETCH.
  - lw then goes to WB; sw then goes to FETCH.
- WB:
  - reg_write_o=1 for one cycle.
  - reg_dst_o=1 only for R-type.
  - mem_to_reg_o=1 only for lw (sw never asserts mem_to_reg_o).
  - Go to FETCH.
- Timeout:
  - If the wait counter reaches MAX_WAIT while still waiting, mem_timeout_o sets, the request is abandoned and the FSM goes to FETCH.
  - An abandoned fetch does not write IR or PC.
  - The counter saturates and never wraps.
- Simultaneous events: mem_ready_i=1 in the same cycle the counter hits MAX_WAIT counts as completion; no timeout.
- Latency per instruction with zero-wait memory (mem_ready_i=1 on first request cycle):
  - Branch and jump: 3 cycles.
  - ALU ops and sw: 4 cycles.
  - lw: 5 cycles.
- Reset mid-operation: any state returns to FETCH next edge; outstanding request strobes drop in the reset cycle.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- Defined: adds outputs cycle_cnt_o [CNT_W] and retired_cnt_o [CNT_W].
  - cycle_cnt_o increments every non-reset cycle.
  - retired_cnt_o increments on every transition into FETCH from EXEC, MEM or WB; illegal and timed-out instructions are not counted.
  - Both counters clear on rst_i and wrap modulo 2^CNT_W.
- Undefined: the ports are absent and there is no counter logic.

Decomposition:
- Package ctrl_pkg holds:
  - Opcode localparams (OP_RTYPE … OP_SW).
  - ALU op codes.
  - State enum typedef state_t.
- One sub-module, mc_op_decode, is natural: the combinational opcode → {class flags, alu_op} table. It is the generalised decoder, shared with the single-cycle core.

Test Plan:
1. Reset held 2 cycles, then mem_ready_i=1 constant, addi (op 8) → state sequence 0,1,2,4,0. In EXEC, alu_op_o=010 and alu_src_o=1. In WB, reg_write_o=1 and reg_dst_o=0.
2. lw (op 35) with mem_ready_i low 3 cycles in MEM → mem_read_o=1 and iord_o=1 for 4 cycles; WB has mem_to_reg_o=1; total 8 cycles.
3. bne (op 5) → EXEC shows branch_o=1, branch_ne_o=1, alu_op_o=011, then FETCH. j (op 2) → jump_o=1, pc_write_o=1 in EXEC.
4. Opcode 63 → illegal_o pulses exactly once in DECODE; FSM returns to FETCH; no reg_write_o or mem strobes.
5. MAX_WAIT=4, mem_ready_i held 0 in FETCH → mem_timeout_o sets after 4 wait cycles, stays 1; ir_write_o never asserts. Repeat with ready arriving exactly on cycle 4 → no timeout.
6. rst_i asserted in MEM during sw → next state FETCH, mem_write_o=0 in the reset cycle. With MULTICYCLE_CTRL_PERF_EN, both counters read 0 after reset.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcodes,
// ALU operation codes, FSM state encoding and the decoded opcode class.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTIU = 6'd9;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [2:0] ALU_FUNCT = 3'b000;
    localparam logic [2:0] ALU_OR    = 3'b001;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_BNE   = 3'b011;
    localparam logic [2:0] ALU_LUI   = 3'b100;
    localparam logic [2:0] ALU_BEQ   = 3'b110;
    localparam logic [2:0] ALU_SLTU  = 3'b111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    typedef struct packed {
        logic legal;
        logic rtype;
        logic branch;
        logic bne;
        logic jump;
        logic load;
        logic store;
        logic imm;
    } op_class_t;

endpackage

// File: rtl/mc_op_decode.sv
// Combinational opcode decoder: maps an opcode onto its instruction class
// flags and ALU operation. Also used by the single-cycle core.
module mc_op_decode
    import ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] op,
    output op_class_t       cls,
    output logic [2:0]      alu_op
);

    // Opcode lookup; unknown opcodes leave every flag clear, including legal.
    always_comb begin
        cls    = '0;
        alu_op = ALU_FUNCT;
        case (op)
            OP_W'(OP_RTYPE): begin
                cls.legal = 1'b1;
                cls.rtype = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            OP_W'(OP_J): begin
                cls.legal = 1'b1;
                cls.jump  = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            OP_W'(OP_BEQ): begin
                cls.legal  = 1'b1;
                cls.branch = 1'b1;
                alu_op     = ALU_BEQ;
            end
            OP_W'(OP_BNE): begin
                cls.legal  = 1'b1;
                cls.branch = 1'b1;
                cls.bne    = 1'b1;
                alu_op     = ALU_BNE;
            end
            OP_W'(OP_ADDI): begin
                cls.legal = 1'b1;
                cls.imm   = 1'b1;
                alu_op    = ALU_ADD;
            end
            OP_W'(OP_SLTIU): begin
                cls.legal = 1'b1;
                cls.imm   = 1'b1;
                alu_op    = ALU_SLTU;
            end
            OP_W'(OP_ORI): begin
                cls.legal = 1'b1;
                cls.imm   = 1'b1;
                alu_op    = ALU_OR;
            end
            OP_W'(OP_LUI): begin
                cls.legal = 1'b1;
                cls.imm   = 1'b1;
                alu_op    = ALU_LUI;
            end
            OP_W'(OP_LW): begin
                cls.legal = 1'b1;
                cls.imm   = 1'b1;
                cls.load  = 1'b1;
                alu_op    = ALU_ADD;
            end
            OP_W'(OP_SW): begin
                cls.legal = 1'b1;
                cls.imm   = 1'b1;
                cls.store = 1'b1;
                alu_op    = ALU_ADD;
            end
            default: begin
                cls    = '0;
                alu_op = ALU_FUNCT;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with a
// variable-latency memory handshake and a bounded-wait watchdog.
// Optional performance counters are enabled with MULTICYCLE_CTRL_PERF_EN.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int OP_W     = 6,
    parameter int ALU_OP_W = 3,
    parameter int MAX_WAIT = 15
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    parameter int CNT_W    = 32
`endif
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [OP_W-1:0]     instr_op_i,
    input  logic                mem_ready_i,
    output logic                pc_write_o,
    output logic                ir_write_o,
    output logic                reg_write_o,
    output logic                reg_dst_o,
    output logic                alu_src_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic                branch_o,
    output logic                branch_ne_o,
    output logic                jump_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic                mem_to_reg_o,
    output logic                iord_o,
    output logic                illegal_o,
    output logic                mem_timeout_o,
    output logic [2:0]          state_o
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]    cycle_cnt_o,
    output logic [CNT_W-1:0]    retired_cnt_o
`endif
);

    // MAX_WAIT is at most 255, so an 8-bit wait counter always suffices.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t          state_q;
    state_t          state_d;
    logic [OP_W-1:0] op_q;
    logic [OP_W-1:0] dec_in;
    logic [7:0]      wait_q;
    logic [7:0]      wait_d;
    logic            wait_expired;
    logic            timeout_q;
    logic            timeout_set;
    op_class_t       cls;
    logic [2:0]      alu3;

    // DECODE judges the live opcode; later states use the copy latched in DECODE.
    assign dec_in       = (state_q == ST_DECODE) ? instr_op_i : op_q;
    assign wait_expired = (wait_q >= WAIT_LAST);

    mc_op_decode #(.OP_W(OP_W)) u_dec (
        .op     (dec_in),
        .cls    (cls),
        .alu_op (alu3)
    );

    // State, latched opcode, wait counter and sticky timeout flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_FETCH;
            op_q      <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q == ST_DECODE) begin
                op_q <= instr_op_i;
            end
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // Next-state and per-state datapath controls; everything is forced low during reset.
    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        timeout_set  = 1'b0;
        pc_write_o   = 1'b0;
        ir_write_o   = 1'b0;
        reg_write_o  = 1'b0;
        reg_dst_o    = 1'b0;
        alu_src_o    = 1'b0;
        alu_op_o     = '0;
        branch_o     = 1'b0;
        branch_ne_o  = 1'b0;
        jump_o       = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        mem_to_reg_o = 1'b0;
        iord_o       = 1'b0;
        illegal_o    = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_read_o = 1'b1;
                if (mem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    wait_d     = '0;
                    state_d    = ST_DECODE;
                end else if (wait_expired) begin
                    timeout_set = 1'b1;
                    wait_d      = '0;
                    state_d     = ST_FETCH;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_DECODE: begin
                if (cls.legal) begin
                    state_d = ST_EXEC;
                end else begin
                    illegal_o = 1'b1;
                    state_d   = ST_FETCH;
                end
            end
            ST_EXEC: begin
                alu_op_o  = ALU_OP_W'(alu3);
                alu_src_o = cls.imm;
                if (cls.branch) begin
                    branch_o    = 1'b1;
                    branch_ne_o = cls.bne;
                    state_d     = ST_FETCH;
                end else if (cls.jump) begin
                    jump_o     = 1'b1;
                    pc_write_o = 1'b1;
                    state_d    = ST_FETCH;
                end else if (cls.load || cls.store) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                iord_o      = 1'b1;
                mem_read_o  = cls.load;
                mem_write_o = cls.store;
                if (mem_ready_i) begin
                    wait_d  = '0;
                    state_d = cls.load ? ST_WB : ST_FETCH;
                end else if (wait_expired) begin
                    timeout_set = 1'b1;
                    wait_d      = '0;
                    state_d     = ST_FETCH;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_WB: begin
                reg_write_o  = 1'b1;
                reg_dst_o    = cls.rtype;
                mem_to_reg_o = cls.load;
                state_d      = ST_FETCH;
            end
            default: begin
                state_d = ST_FETCH;
                wait_d  = '0;
            end
        endcase

        if (rst_i) begin
            timeout_set  = 1'b0;
            pc_write_o   = 1'b0;
            ir_write_o   = 1'b0;
            reg_write_o  = 1'b0;
            reg_dst_o    = 1'b0;
            alu_src_o    = 1'b0;
            alu_op_o     = '0;
            branch_o     = 1'b0;
            branch_ne_o  = 1'b0;
            jump_o       = 1'b0;
            mem_read_o   = 1'b0;
            mem_write_o  = 1'b0;
            mem_to_reg_o = 1'b0;
            iord_o       = 1'b0;
            illegal_o    = 1'b0;
        end
    end

    assign mem_timeout_o = timeout_q;
    assign state_o       = state_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic retire;

    // An instruction retires when it returns to FETCH from EXEC, MEM or WB without timing out.
    assign retire = !rst_i && !timeout_set && (state_d == ST_FETCH) &&
                    (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB);

    // Free-running cycle counter and retired-instruction counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_cnt_o   <= '0;
            retired_cnt_o <= '0;
        end else begin
            cycle_cnt_o <= cycle_cnt_o + 1'b1;
            if (retire) begin
                retired_cnt_o <= retired_cnt_o + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: table of per-opcode runs,
// directed multi-cycle corner cases, then randomized traffic against a
// behavioural model. Counter checks appear when MULTICYCLE_CTRL_PERF_EN is set.
module tb_multicycle_ctrl;

    localparam int MAXW = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       ready;
    logic [5:0] op;

    logic       pc_write, ir_write, reg_write, reg_dst, alu_src;
    logic [2:0] alu_op;
    logic       branch, branch_ne, jump, mem_read, mem_write, mem_to_reg;
    logic       iord, illegal, mem_timeout;
    logic [2:0] state;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cyc_cnt, ret_cnt;
`endif

    multicycle_ctrl #(.MAX_WAIT(MAXW)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .instr_op_i    (op),
        .mem_ready_i   (ready),
        .pc_write_o    (pc_write),
        .ir_write_o    (ir_write),
        .reg_write_o   (reg_write),
        .reg_dst_o     (reg_dst),
        .alu_src_o     (alu_src),
        .alu_op_o      (alu_op),
        .branch_o      (branch),
        .branch_ne_o   (branch_ne),
        .jump_o        (jump),
        .mem_read_o    (mem_read),
        .mem_write_o   (mem_write),
        .mem_to_reg_o  (mem_to_reg),
        .iord_o        (iord),
        .illegal_o     (illegal),
        .mem_timeout_o (mem_timeout),
        .state_o       (state)
`ifdef MULTICYCLE_CTRL_PERF_EN
        ,
        .cycle_cnt_o   (cyc_cnt),
        .retired_cnt_o (ret_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src;
        logic [2:0] alu_op;
        logic       branch;
        logic       branch_ne;
        logic       jump;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       iord;
        logic       illegal;
        logic       timeout;
        logic [2:0] state;
    } outs_t;

    typedef struct {
        logic [5:0] op;
        int         cycles;
        logic [2:0] alu;
        logic       src;
        int         ill;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Behavioural reference: instruction phase, latched opcode, wait count, flags.
    int          m_state;
    logic [5:0]  m_op;
    int          m_wait;
    logic        m_to;
    logic [31:0] m_cyc;
    logic [31:0] m_ret;

    outs_t cur;
    int    irw_cnt;

    int    r_cycles, r_ill, r_rdio, r_regw, r_memw;
    outs_t r_ex, r_wb;
    int    r_seq[8];

    function automatic bit is_legal(input logic [5:0] o);
        return o inside {6'd0, 6'd2, 6'd4, 6'd5, 6'd8, 6'd9, 6'd13, 6'd15, 6'd35, 6'd43};
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] o);
        case (o)
            6'd4:         return 3'b110;
            6'd5:         return 3'b011;
            6'd8:         return 3'b010;
            6'd9:         return 3'b111;
            6'd13:        return 3'b001;
            6'd15:        return 3'b100;
            6'd35, 6'd43: return 3'b010;
            default:      return 3'b000;
        endcase
    endfunction

    function automatic outs_t model_out();
        outs_t o;
        o         = '0;
        o.timeout = m_to;
        o.state   = 3'(m_state);
        if (!rst) begin
            case (m_state)
                0: begin
                    o.mem_read = 1'b1;
                    o.ir_write = ready;
                    o.pc_write = ready;
                end
                1: o.illegal = !is_legal(op);
                2: begin
                    o.alu_op  = alu_of(m_op);
                    o.alu_src = m_op inside {6'd8, 6'd9, 6'd13, 6'd15, 6'd35, 6'd43};
                    if (m_op == 6'd4 || m_op == 6'd5) begin
                        o.branch    = 1'b1;
                        o.branch_ne = (m_op == 6'd5);
                    end
                    if (m_op == 6'd2) begin
                        o.jump     = 1'b1;
                        o.pc_write = 1'b1;
                    end
                end
                3: begin
                    o.iord      = 1'b1;
                    o.mem_read  = (m_op == 6'd35);
                    o.mem_write = (m_op == 6'd43);
                end
                4: begin
                    o.reg_write  = 1'b1;
                    o.reg_dst    = (m_op == 6'd0);
                    o.mem_to_reg = (m_op == 6'd35);
                end
                default: ;
            endcase
        end
        return o;
    endfunction

    function automatic void model_step();
        if (rst) begin
            m_state = 0;
            m_wait  = 0;
            m_to    = 1'b0;
            m_cyc   = '0;
            m_ret   = '0;
            return;
        end
        m_cyc = m_cyc + 1;
        case (m_state)
            0: begin
                if (ready) begin
                    m_wait  = 0;
                    m_state = 1;
                end else begin
                    m_wait++;
                    if (m_wait == MAXW) begin
                        m_to   = 1'b1;
                        m_wait = 0;
                    end
                end
            end
            1: begin
                m_op    = op;
                m_state = is_legal(op) ? 2 : 0;
            end
            2: begin
                if (m_op inside {6'd2, 6'd4, 6'd5}) begin
                    m_state = 0;
                    m_ret   = m_ret + 1;
                end else if (m_op inside {6'd35, 6'd43}) begin
                    m_state = 3;
                end else begin
                    m_state = 4;
                end
            end
            3: begin
                if (ready) begin
                    m_wait = 0;
                    if (m_op == 6'd35) begin
                        m_state = 4;
                    end else begin
                        m_state = 0;
                        m_ret   = m_ret + 1;
                    end
                end else begin
                    m_wait++;
                    if (m_wait == MAXW) begin
                        m_to    = 1'b1;
                        m_wait  = 0;
                        m_state = 0;
                    end
                end
            end
            default: begin
                m_state = 0;
                m_ret   = m_ret + 1;
            end
        endcase
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: compare all outputs against the model mid-cycle, then advance both.
    task automatic applyStimulus(input string tag);
        outs_t exp;
        @(negedge clk);
        exp = model_out();
        cur = {pc_write, ir_write, reg_write, reg_dst, alu_src, alu_op, branch, branch_ne,
               jump, mem_read, mem_write, mem_to_reg, iord, illegal, mem_timeout, state};
        irw_cnt += int'(cur.ir_write);
        total++;
        if (cur !== exp) begin
            bad++;
            $display("[TB] FAIL %s outputs: got %h, want %h (t=%0t)", tag, cur, exp, $time);
        end
`ifdef MULTICYCLE_CTRL_PERF_EN
        total++;
        if (cyc_cnt !== m_cyc || ret_cnt !== m_ret) begin
            bad++;
            $display("[TB] FAIL %s counters: got %0d/%0d, want %0d/%0d", tag, cyc_cnt, ret_cnt, m_cyc, m_ret);
        end
`endif
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) applyStimulus("reset");
        rst = 1'b0;
    endtask

    // Run one instruction from FETCH back to FETCH, stalling MEM for 'stall' cycles.
    task automatic run_instr(input logic [5:0] o, input int stall);
        int left;
        left     = stall;
        op       = o;
        r_cycles = 0;
        r_ex     = '0;
        r_wb     = '0;
        r_ill    = 0;
        r_rdio   = 0;
        r_regw   = 0;
        r_memw   = 0;
        do begin
            if (state == 3'd3 && left > 0) begin
                ready = 1'b0;
                left--;
            end else begin
                ready = 1'b1;
            end
            applyStimulus("instr");
            if (r_cycles < 8) r_seq[r_cycles] = int'(cur.state);
            if (cur.state == 3'd2) r_ex = cur;
            if (cur.state == 3'd4) r_wb = cur;
            r_ill  += int'(cur.illegal);
            r_rdio += int'(cur.mem_read && cur.iord);
            r_regw += int'(cur.reg_write);
            r_memw += int'(cur.mem_write);
            r_cycles++;
        end while (state != 3'd0 && r_cycles < 30);
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{6'd0,  4, 3'b000, 1'b0, 0};
        vecs[1]  = '{6'd2,  3, 3'b000, 1'b0, 0};
        vecs[2]  = '{6'd4,  3, 3'b110, 1'b0, 0};
        vecs[3]  = '{6'd5,  3, 3'b011, 1'b0, 0};
        vecs[4]  = '{6'd8,  4, 3'b010, 1'b1, 0};
        vecs[5]  = '{6'd9,  4, 3'b111, 1'b1, 0};
        vecs[6]  = '{6'd13, 4, 3'b001, 1'b1, 0};
        vecs[7]  = '{6'd15, 4, 3'b100, 1'b1, 0};
        vecs[8]  = '{6'd35, 5, 3'b010, 1'b1, 0};
        vecs[9]  = '{6'd43, 4, 3'b010, 1'b1, 0};
        vecs[10] = '{6'd63, 2, 3'b000, 1'b0, 1};
        vecs[11] = '{6'd1,  2, 3'b000, 1'b0, 1};

        rst     = 1'b1;
        ready   = 1'b0;
        op      = 6'd0;
        m_op    = 6'd0;
        irw_cnt = 0;
        @(posedge clk);
        model_step();
        #1;

        // Reset held two cycles, then addi with zero-wait memory.
        do_reset(2);
        check_val("reset_state", 32'(state), 32'd0);
        check_val("reset_timeout", 32'(mem_timeout), 32'd0);
`ifdef MULTICYCLE_CTRL_PERF_EN
        check_val("reset_cycle_cnt", cyc_cnt, 32'd0);
        check_val("reset_retired_cnt", ret_cnt, 32'd0);
`endif
        run_instr(6'd8, 0);
        check_val("addi_seq0", 32'(r_seq[0]), 32'd0);
        check_val("addi_seq1", 32'(r_seq[1]), 32'd1);
        check_val("addi_seq2", 32'(r_seq[2]), 32'd2);
        check_val("addi_seq3", 32'(r_seq[3]), 32'd4);
        check_val("addi_end_state", 32'(state), 32'd0);
        check_val("addi_alu_op", 32'(r_ex.alu_op), 32'b010);
        check_val("addi_alu_src", 32'(r_ex.alu_src), 32'd1);
        check_val("addi_reg_write", 32'(r_wb.reg_write), 32'd1);
        check_val("addi_reg_dst", 32'(r_wb.reg_dst), 32'd0);

        // Per-opcode table: latency, EXEC ALU controls and illegal pulses.
        for (int i = 0; i < 12; i++) begin
            run_instr(vecs[i].op, 0);
            check_val($sformatf("tbl_op%0d_cycles", vecs[i].op), 32'(r_cycles), 32'(vecs[i].cycles));
            check_val($sformatf("tbl_op%0d_alu", vecs[i].op), 32'(r_ex.alu_op), 32'(vecs[i].alu));
            check_val($sformatf("tbl_op%0d_src", vecs[i].op), 32'(r_ex.alu_src), 32'(vecs[i].src));
            check_val($sformatf("tbl_op%0d_illegal", vecs[i].op), 32'(r_ill), 32'(vecs[i].ill));
            if (vecs[i].ill != 0) begin
                check_val($sformatf("tbl_op%0d_strobes", vecs[i].op), 32'(r_regw + r_memw + r_rdio), 32'd0);
            end
        end

        // lw with a three-cycle memory stall.
        run_instr(6'd35, 3);
        check_val("lw_stall_cycles", 32'(r_cycles), 32'd8);
        check_val("lw_stall_rd_iord", 32'(r_rdio), 32'd4);
        check_val("lw_mem_to_reg", 32'(r_wb.mem_to_reg), 32'd1);

        // bne and j.
        run_instr(6'd5, 0);
        check_val("bne_branch", 32'(r_ex.branch), 32'd1);
        check_val("bne_sense", 32'(r_ex.branch_ne), 32'd1);
        check_val("bne_alu_op", 32'(r_ex.alu_op), 32'b011);
        check_val("bne_end_state", 32'(state), 32'd0);
        run_instr(6'd2, 0);
        check_val("j_jump", 32'(r_ex.jump), 32'd1);
        check_val("j_pc_write", 32'(r_ex.pc_write), 32'd1);

        // Fetch timeout after MAXW unready cycles; the flag is sticky.
        do_reset(1);
        irw_cnt = 0;
        ready   = 1'b0;
        repeat (MAXW - 1) applyStimulus("fetch_wait");
        check_val("timeout_not_yet", 32'(mem_timeout), 32'd0);
        applyStimulus("fetch_wait");
        check_val("timeout_set", 32'(mem_timeout), 32'd1);
        check_val("timeout_state", 32'(state), 32'd0);
        repeat (3) applyStimulus("fetch_wait");
        check_val("timeout_sticky", 32'(mem_timeout), 32'd1);
        check_val("timeout_no_ir_write", 32'(irw_cnt), 32'd0);

        // Ready on the last allowed cycle completes the fetch.
        do_reset(1);
        ready = 1'b0;
        repeat (MAXW - 1) applyStimulus("fetch_wait");
        ready = 1'b1;
        applyStimulus("fetch_late");
        check_val("late_ready_no_timeout", 32'(mem_timeout), 32'd0);
        check_val("late_ready_decode", 32'(state), 32'd1);
        op = 6'd0;
        applyStimulus("drain");
        applyStimulus("drain");
        applyStimulus("drain");

        // Reset during a stalled sw in MEM.
        do_reset(1);
        op    = 6'd43;
        ready = 1'b1;
        repeat (3) applyStimulus("sw_pre");
        ready = 1'b0;
        applyStimulus("sw_mem");
        check_val("sw_mem_write", 32'(cur.mem_write), 32'd1);
        rst = 1'b1;
        applyStimulus("sw_reset");
        rst = 1'b0;
        check_val("sw_reset_mem_write", 32'(cur.mem_write), 32'd0);
        check_val("sw_reset_state", 32'(state), 32'd0);
`ifdef MULTICYCLE_CTRL_PERF_EN
        check_val("sw_reset_cycle_cnt", cyc_cnt, 32'd0);
        check_val("sw_reset_retired_cnt", ret_cnt, 32'd0);
`endif

        // Randomized traffic; opcodes change only while fetching.
        for (int i = 0; i < 3000; i++) begin
            int pct;
            pct   = ((i / 250) % 2 == 0) ? 75 : 30;
            ready = ($urandom_range(0, 99) < pct);
            rst   = ($urandom_range(0, 199) == 0);
            if (m_state == 0) begin
                if ($urandom_range(0, 99) < 85) begin
                    case ($urandom_range(0, 9))
                        0: op = 6'd0;
                        1: op = 6'd2;
                        2: op = 6'd4;
                        3: op = 6'd5;
                        4: op = 6'd8;
                        5: op = 6'd9;
                        6: op = 6'd13;
                        7: op = 6'd15;
                        8: op = 6'd35;
                        default: op = 6'd43;
                    endcase
                end else begin
                    op = 6'($urandom_range(0, 63));
                end
            end
            applyStimulus("random");
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
